// File: rtl/y86_imem_writer.sv
// Serializes decoded Y86-64 instructions into instruction-memory byte writes, one byte per cycle.
// Optional IMEM_WRITER_HALT_LOCK_EN: after a halt is fully written, the writer locks until reset.
module y86_imem_writer #(
  parameter int unsigned MEM_BYTES  = 128,
  parameter logic [63:0] START_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic        org_valid,
  input  logic [63:0] org_addr,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [63:0] next_pc,
  output logic        busy,
  output logic        done,
  output logic        enc_error,
  output logic        ovf_error
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [3:0]  len_q, len_d, idx_q, idx_d;
  logic [63:0] next_pc_q, next_pc_d;
  logic        wr_en_q, wr_en_d;
  logic [63:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d, enc_error_q, enc_error_d, ovf_error_q, ovf_error_d;
  logic        lock_q, lock_d;

  logic [3:0]  in_len;
  logic        in_fits;

  // Zero marks an unencodable icode.
  function automatic logic [3:0] enc_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:        enc_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  enc_len = 4'd2;
      4'h3, 4'h4, 4'h5:        enc_len = 4'd10;
      4'h7, 4'h8:              enc_len = 4'd9;
      default:                 enc_len = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] enc_byte(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [63:0] vc, input logic [3:0] idx);
    logic [3:0] len;
    logic [3:0] vofs;
    len  = enc_len(ic);
    vofs = (len == 4'd10) ? idx - 4'd2 : idx - 4'd1;
    if (idx == 4'd0)
      enc_byte = {ic, fn};
    else if ((len == 4'd2 || len == 4'd10) && idx == 4'd1)
      enc_byte = {ra, rb};
    else
      enc_byte = vc[{vofs[2:0], 3'b000} +: 8];
  endfunction

  assign in_len  = enc_len(icode);
  assign in_fits = ({1'b0, next_pc_q} + 65'(in_len)) <= 65'(MEM_BYTES);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    icode_d     = icode_q;
    ifun_d      = ifun_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    len_d       = len_q;
    idx_d       = idx_q;
    next_pc_d   = next_pc_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    enc_error_d = 1'b0;
    ovf_error_d = 1'b0;
    lock_d      = lock_q;

    case (state_q)
      IDLE: begin
        if (!lock_q) begin
          if (org_valid) begin
            next_pc_d = org_addr;
          end else if (in_valid) begin
            icode_d = icode;
            ifun_d  = ifun;
            ra_d    = rA;
            rb_d    = rB;
            valc_d  = valC;
            if (icode > 4'hB) begin
              enc_error_d = 1'b1;
            end else if (!in_fits) begin
              ovf_error_d = 1'b1;
            end else begin
              // Byte 0 is registered on the accept edge so the first write lands one cycle later.
              state_d   = EMIT;
              len_d     = in_len;
              idx_d     = 4'd0;
              wr_en_d   = 1'b1;
              wr_addr_d = next_pc_q;
              wr_data_d = enc_byte(icode, ifun, rA, rB, valC, 4'd0);
              done_d    = (in_len == 4'd1);
            end
          end
        end
      end
      EMIT: begin
        if (idx_q == len_q - 4'd1) begin
          state_d   = IDLE;
          next_pc_d = next_pc_q + 64'(len_q);
`ifdef IMEM_WRITER_HALT_LOCK_EN
          if (icode_q == 4'h0) lock_d = 1'b1;
`endif
        end else begin
          idx_d     = idx_q + 4'd1;
          wr_en_d   = 1'b1;
          wr_addr_d = next_pc_q + 64'(idx_q) + 64'd1;
          wr_data_d = enc_byte(icode_q, ifun_q, ra_q, rb_q, valc_q, idx_q + 4'd1);
          done_d    = (idx_q + 4'd1 == len_q - 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      icode_q     <= 4'd0;
      ifun_q      <= 4'd0;
      ra_q        <= 4'd0;
      rb_q        <= 4'd0;
      valc_q      <= 64'd0;
      len_q       <= 4'd0;
      idx_q       <= 4'd0;
      next_pc_q   <= START_ADDR;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 64'd0;
      wr_data_q   <= 8'd0;
      done_q      <= 1'b0;
      enc_error_q <= 1'b0;
      ovf_error_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      next_pc_q   <= next_pc_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      enc_error_q <= enc_error_d;
      ovf_error_q <= ovf_error_d;
      lock_q      <= lock_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !org_valid && !lock_q;
  assign busy      = (state_q == EMIT);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign next_pc   = next_pc_q;
  assign done      = done_q;
  assign enc_error = enc_error_q;
  assign ovf_error = ovf_error_q;

endmodule

// File: tb/tb_y86_imem_writer.sv
// Self-checking bench for y86_imem_writer: directed cases plus random instructions against a byte-level model.
module tb_y86_imem_writer;

  localparam int MEM = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc;
  logic        org_valid;
  logic [63:0] org_addr;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [7:0]  wr_data;
  logic [63:0] next_pc;
  logic        busy, done, enc_error, ovf_error;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] pc;

  y86_imem_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(ra), .rB(rb), .valC(valc),
    .org_valid(org_valid), .org_addr(org_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .next_pc(next_pc),
    .busy(busy), .done(done), .enc_error(enc_error), .ovf_error(ovf_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic [3:0] ic);
    if (ic == 0 || ic == 1 || ic == 9) return 1;
    if (ic == 2 || ic == 6 || ic == 10 || ic == 11) return 2;
    if (ic >= 3 && ic <= 5) return 10;
    if (ic == 7 || ic == 8) return 9;
    return 0;
  endfunction

  // Full instruction: expects accept, bytes, done, pointer advance (or an error pulse).
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] c, input int abort_at);
    int len, pos;
    logic [7:0] bytes[10];
    logic [64:0] end_p;
    len = ref_len(ic);
    for (int i = 0; i < 10; i++) bytes[i] = 8'h00;
    bytes[0] = 8'(int'(ic) * 16 + int'(fn));
    pos = 1;
    if (len == 2 || len == 10) begin
      bytes[1] = 8'(int'(a) * 16 + int'(b));
      pos = 2;
    end
    for (int i = 0; i < len - pos; i++) bytes[pos + i] = 8'((c >> (8 * i)) & 64'hFF);

    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; icode = ic; ifun = fn; ra = a; rb = b; valc = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (len == 0) begin
      check("enc_error", 64'(enc_error), 64'd1);
      check("enc_no_wr", 64'(wr_en), 64'd0);
      check("enc_pc", next_pc, pc);
      return;
    end
    end_p = {1'b0, pc} + 65'(len);
    if (end_p > 65'(MEM)) begin
      check("ovf_error", 64'(ovf_error), 64'd1);
      check("ovf_no_wr", 64'(wr_en), 64'd0);
      check("ovf_pc", next_pc, pc);
      return;
    end
    for (int k = 0; k < len; k++) begin
      check("wr_en", 64'(wr_en), 64'd1);
      check("wr_addr", wr_addr, pc + 64'(k));
      check("wr_data", 64'(wr_data), 64'(bytes[k]));
      check("done", 64'(done), 64'(k == len - 1));
      check("busy_ready", {62'd0, busy, in_ready}, 64'd2);
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_wr_en", 64'(wr_en), 64'd0);
        check("abort_pc", next_pc, 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        pc = 64'd0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("post_wr_en", 64'(wr_en), 64'd0);
    check("post_done", 64'(done), 64'd0);
    check("post_data_hold", 64'(wr_data), 64'(bytes[len - 1]));
    pc = pc + 64'(len);
    check("post_pc", next_pc, pc);
  endtask

  task automatic org(input logic [63:0] a, input bit with_instr);
    @(negedge clk);
    org_valid = 1'b1; org_addr = a;
    if (with_instr) begin
      in_valid = 1'b1; icode = 4'h1; ifun = 4'h0;
    end
    #1;
    check("org_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    org_valid = 1'b0; in_valid = 1'b0;
    check("org_no_wr", 64'(wr_en), 64'd0);
    check("org_pc", next_pc, a);
    pc = a;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; icode = '0; ifun = '0; ra = '0; rb = '0; valc = '0;
    org_valid = 1'b0; org_addr = '0; pc = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_outs", {57'd0, wr_en, busy, done, enc_error, ovf_error, 2'b00}, 64'd0);
    check("rst_addr", wr_addr, 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    check("rst_pc", next_pc, 64'd0);

    send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, -1);
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, -1);
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h40, -1);
    send(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, -1);
    check("pc_22", next_pc, 64'd22);

    org(64'h30, 1'b1);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, -1);
    check("pc_31", next_pc, 64'h31);
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'd5, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) org(64'($urandom_range(0, MEM - 1)), 1'($urandom_range(0, 1)));
      send(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), {$urandom, $urandom}, -1);
    end

    org(64'h40, 1'b0);
    send(4'h5, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 3);

    org(64'd118, 1'b0);
    send(4'h3, 4'h0, 4'hF, 4'h7, 64'hDEADBEEFCAFEF00D, -1);
    check("pc_128", next_pc, 64'd128);

    org(64'd120, 1'b0);
    send(4'h7, 4'h0, 4'hF, 4'hF, 64'h50, -1);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, -1);
    check("pc_121", next_pc, 64'd121);

`ifdef IMEM_WRITER_HALT_LOCK_EN
    @(negedge clk);
    in_valid = 1'b1; icode = 4'h1; ifun = 4'h0;
    for (int i = 0; i < 3; i++) begin
      check("lock_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("lock_no_wr", 64'(wr_en), 64'd0);
      check("lock_pc", next_pc, 64'd121);
    end
    org_valid = 1'b1; org_addr = 64'd5;
    @(posedge clk);
    @(negedge clk);
    check("lock_org_ignored", next_pc, 64'd121);
    in_valid = 1'b0; org_valid = 1'b0;
`else
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, -1);
    check("pc_122", next_pc, 64'd122);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_imem_writer.md
Name: y86_imem_writer

Overview:
- Encoder/loader counterpart of the Y86-64 fetch stage: accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and serializes it into instruction-memory byte writes, one byte per cycle.
- Writes use exactly the byte layout fetch reads back, at an auto-incrementing program pointer.
- Used by test benches and the boot path to build program images in the 128-byte instruction memory without a pre-assembled text file.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; valid addresses 0..MEM_BYTES-1.
- START_ADDR, 0, program pointer value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  writer can accept an instruction this cycle.
- icode  input  4  instruction code.
- ifun  input  4  function code.
- rA  input  4  first register specifier.
- rB  input  4  second register specifier.
- valC  input  64  constant, displacement or destination.
- org_valid  input  1  relocate the program pointer (.pos directive).
- org_addr  input  64  new program pointer value.
- wr_en  output  1  byte write strobe to instruction memory.
- wr_addr  output  64  byte address.
- wr_data  output  8  byte value.
- next_pc  output  64  current program pointer (address of the next instruction to be written).
- busy  output  1  high while in EMIT.
- done  output  1  one-cycle pulse on the cycle the last byte of an instruction is written.
- enc_error  output  1  one-cycle pulse: icode > 0xB was rejected.
- ovf_error  output  1  one-cycle pulse: the instruction would cross MEM_BYTES and was rejected.

Behaviour:
- Reset values:
  - in_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, enc_error=0, ovf_error=0.
  - next_pc=START_ADDR; state IDLE.
- Encoding lengths (len):
  - icode 0x0, 0x1, 0x9: 1 byte.
  - icode 0x2, 0x6, 0xA, 0xB: 2 bytes.
  - icode 0x3, 0x4, 0x5: 10 bytes.
  - icode 0x7, 0x8: 9 bytes.
- Byte layout:
  - byte0 = {icode, ifun}, icode in bits 7:4.
  - Register byte = {rA, rB}, rA in bits 7:4; present for 2- and 10-byte forms.
  - valC is written little-endian, LSB first: bytes 2..9 in 10-byte forms, bytes 1..8 in 9-byte forms.
- IDLE state:
  - in_ready = !org_valid.
  - If org_valid: next_pc <= org_addr; org has priority over in_valid; no write.
  - Else, if in_valid: latch all fields, then:
    - icode > 0xB: enc_error pulse next cycle, no write, next_pc unchanged, stay IDLE.
    - next_pc + len > MEM_BYTES, computed in 65 bits so no wrap: ovf_error pulse, no write, stay IDLE.
    - Otherwise: go to EMIT with byte index = 0.
- EMIT state:
  - in_ready=0, busy=1; org_valid is ignored.
  - Each cycle: wr_en=1, wr_addr = next_pc + idx, wr_data = byte[idx]; idx increments.
  - On idx == len-1: done=1 in that same cycle; next_pc <= next_pc + len; return to IDLE.
- Timing:
  - Accept at edge T; first write at cycle T+1; last write at cycle T+len.
  - Throughput is one instruction per len+1 cycles.
- Outputs:
  - wr_en, wr_addr and wr_data are registered.
  - wr_data holds its last value when wr_en=0.
- Reset mid-EMIT: the next cycle has wr_en=0, next_pc=START_ADDR and state IDLE; the partial instruction is abandoned and bytes already written are not cleaned up.
- ifun, rA and rB are never range-checked; they are written verbatim.
- Unused fields are not written: rA/rB for icode 0/1/7/8/9, valC for 2-byte forms.

Optional Feature:
- Macro IMEM_WRITER_HALT_LOCK_EN.
- Defined: after a halt (icode 0x0) is fully written, the writer locks. in_ready=0 and org_valid is ignored until rst.
- Undefined: a halt is treated like any other 1-byte instruction and the writer keeps accepting input.

Test Plan:
- Reset, then irmovq: icode=3, ifun=0, rA=F, rB=3, valC=0x0123456789ABCDEF -> writes at addr 0..9 of 30 F3 EF CD AB 89 67 45 23 01; done on the 10th write cycle; next_pc=10; in_ready=0 throughout.
- Back-to-back instructions:
  - addq (6,0,rA=2,rB=3) -> 60 23 at 10,11.
  - call (8,0,valC=0x40) -> 80 40 00 00 00 00 00 00 00 at 12..20.
  - ret (9,0) -> 90 at 21; next_pc=22.
- org_valid=1 with org_addr=0x30 and in_valid=1 in the same cycle -> next_pc=0x30, no write, in_ready=0 that cycle. Then a nop -> 10 written at 0x30, next_pc=0x31.
- Boundary checks, with next_pc=120:
  - jmp (7,0), 9 bytes -> ovf_error pulse, no wr_en, next_pc stays 120.
  - Then halt -> 00 at 120, next_pc=121.
  - With next_pc=118, a 10-byte irmovq: 118+10=128 is not > 128, so it is accepted and writes 118..127.
- icode=0xC -> enc_error pulse, no write, next_pc unchanged. Separately, assert rst after the 4th byte of a mrmovq -> wr_en=0 next cycle, next_pc=0, in_ready=1.
- With IMEM_WRITER_HALT_LOCK_EN defined: halt -> 00 written; then in_valid with nop -> in_ready stays 0, no write until rst.
